unified_mem_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the pipelined CPU. It holds at most one outstanding memory transaction and gives data accesses priority over fetches. It raises stall requests toward the pipeline control and hazard logic. It also discards fetches made obsolete by a wrong-prediction or jr redirect, and recovers from a hung memory via a watchdog.

---
 rtl/unified_mem_arbiter_pkg.sv | 27 ++
 rtl/unified_mem_arbiter_watchdog.sv | 28 ++
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// State and owner encodings plus the default watchdog limit.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

    localparam int DEF_TIMEOUT = 255;

    function automatic arb_owner_t state_owner(input arb_state_t s);
        case (s)
            ST_IF_BUSY: return OWN_IF;
            ST_DM_BUSY: return OWN_DM;
            default:    return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_watchdog.sv
// Busy-cycle watchdog: expires on the TIMEOUT-th enabled cycle
// since the last clear; the counter saturates instead of wrapping.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (MEM).
// One outstanding transaction, data priority, kill-drop and watchdog.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    arb_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_valid;
    logic              r_dm_valid;
    logic              r_bus_err;
    logic              r_drop;

    logic       w_idle;
    logic       w_if_req;
    logic       w_dm_req;
    logic       w_grant;
    logic       w_wd_en;
    logic       w_expire;
    logic       w_if_drop;
    arb_owner_t w_owner;

    // A requester still holds req during its valid cycle; mask it there
    // so the completed access is not granted a second time.
    assign w_if_req  = if_req & ~r_if_valid;
    assign w_dm_req  = dm_req & ~r_dm_valid;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_grant   = w_idle & (w_if_req | w_dm_req);
    assign w_wd_en   = ~w_idle & ~mem_ack;
    assign w_if_drop = r_drop | if_kill;
    assign w_owner   = state_owner(r_state);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_grant),
        .i_enable (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_idle) begin
                priority case (1'b1)
                    w_dm_req: begin
                        r_state     <= ST_DM_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                    end
                    w_if_req: begin
                        r_state    <= ST_IF_BUSY;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr;
                    end
                    default: ;
                endcase
            end else if (mem_ack) begin
                r_state   <= ST_IDLE;
                r_mem_req <= 1'b0;
                r_drop    <= 1'b0;
                if (w_owner == OWN_DM) begin
                    r_dm_valid <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                    end
                end else if (!w_if_drop) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= mem_rdata;
                end
            end else if (w_expire) begin
                r_state   <= ST_IDLE;
                r_mem_req <= 1'b0;
                r_drop    <= 1'b0;
                r_bus_err <= 1'b1;
            end else if ((r_state == ST_IF_BUSY) && if_kill) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign if_stall  = w_if_req;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign dm_stall  = w_dm_req;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a latency-configurable
// memory model; expected completions are queued by the stimulus.
module tb_unified_mem_arbiter;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } ev_t;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_IF   = 2'd1;
    localparam logic [1:0] K_DM   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int  lat = 1;
    bit  mem_never = 1'b0;
    bit  inject_ack = 1'b0;
    int  n_total = 0;
    int  n_pass = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h00A00093;
            32'h80:  return 32'h00000013;
            32'h100: return 32'h12345678;
            default: return a ^ 32'hA5A50000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_if();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (if_valid === 1'b1) break;
        end
        chk("if_valid_seen", 32'(if_valid), 32'd1);
    endtask

    task automatic wait_dm();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (dm_valid === 1'b1) break;
        end
        chk("dm_valid_seen", 32'(dm_valid), 32'd1);
    endtask

    // Memory: acks in the lat-th cycle of mem_req, drives just after posedge
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (inject_ack) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end else if (mem_req === 1'b1) begin
                cnt++;
                if (!mem_never && cnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every completion or bus error must match the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1 || dm_valid === 1'b1 || bus_err === 1'b1) begin
                ev_t e;
                logic [1:0] k;
                logic [31:0] d;
                k = if_valid ? K_IF : (dm_valid ? K_DM : K_ERR);
                d = if_valid ? if_rdata : (dm_valid ? dm_rdata : 32'd0);
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin
                    e.kind = K_NONE;
                    e.data = '0;
                end
                chk("valid_exclusive", 32'(if_valid & dm_valid), 32'd0);
                chk("event_kind", 32'(k), 32'(e.kind));
                chk("event_data", d, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if_req = 0; if_kill = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch alone, ack two cycles after mem_req rises
        lat = 3;
        push(K_IF, 32'h00A00093);
        if_req = 1; if_addr = 32'h40;
        #1;
        chk("f1_stall0", 32'(if_stall), 32'd1);
        chk("f1_req_grant_cycle", 32'(mem_req), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("f1_mem_req", 32'(mem_req), 32'd1);
                chk("f1_mem_addr", mem_addr, 32'h40);
                chk("f1_mem_we", 32'(mem_we), 32'd0);
            end
            chk("f1_stall", 32'(if_stall), (k < 4) ? 32'd1 : 32'd0);
            chk("f1_valid", 32'(if_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        if_req = 0;
        @(negedge clk);
        chk("f1_valid_pulse", 32'(if_valid), 32'd0);
        chk("f1_req_low", 32'(mem_req), 32'd0);

        // Simultaneous requests: data first, then the fetch
        lat = 1;
        push(K_DM, 32'h12345678);
        push(K_IF, 32'h00000013);
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        chk("sim_dm_first", mem_addr, 32'h100);
        chk("sim_dm_req", 32'(mem_req), 32'd1);
        wait_dm();
        dm_req = 0;
        @(negedge clk);
        chk("sim_if_next", mem_addr, 32'h80);
        chk("sim_if_req", 32'(mem_req), 32'd1);
        wait_if();
        if_req = 0;

        // Store: dm_rdata keeps the earlier load value
        lat = 2;
        push(K_DM, 32'h12345678);
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_addr", mem_addr, 32'h200);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_dm();
        dm_req = 0; dm_we = 0;

        // Kill while the fetch is in flight
        lat = 3;
        if_req = 1; if_addr = 32'h300;
        @(negedge clk);
        if_kill = 1;
        @(negedge clk);
        if_kill = 0;
        chk("k1_addr_frozen", mem_addr, 32'h300);
        if_addr = 32'h40;
        push(K_IF, 32'h00A00093);
        wait_if();
        if_req = 0;

        // Kill in the same cycle as mem_ack
        lat = 2;
        @(negedge clk);
        if_req = 1; if_addr = 32'h304;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_ack === 1'b1) break;
        end
        chk("k2_ack_seen", 32'(mem_ack), 32'd1);
        if_kill = 1;
        @(negedge clk);
        if_kill = 0;
        chk("k2_no_valid", 32'(if_valid), 32'd0);
        if_addr = 32'h80;
        push(K_IF, 32'h00000013);
        wait_if();
        if_req = 0;

        // Hung memory: watchdog expiry then retry
        lat = 1;
        mem_never = 1;
        @(negedge clk);
        push(K_ERR, 32'd0);
        push(K_DM, 32'hA5A50104);
        dm_req = 1; dm_we = 0; dm_addr = 32'h104;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                chk("wd_req_held", 32'(mem_req), 32'd1);
            end else begin
                chk("wd_req_drop", 32'(mem_req), 32'd0);
                chk("wd_bus_err", 32'(bus_err), 32'd1);
                chk("wd_no_valid", 32'(dm_valid), 32'd0);
                mem_never = 0;
            end
        end
        @(negedge clk);
        chk("wd_retry_req", 32'(mem_req), 32'd1);
        wait_dm();
        dm_req = 0;

        // Reset during DM_BUSY, late ack afterwards
        mem_never = 1;
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 32'h108;
        @(negedge clk);
        @(negedge clk);
        chk("r_busy", 32'(mem_req), 32'd1);
        rst = 1;
        dm_req = 0;
        @(negedge clk);
        chk("r_mem_req", 32'(mem_req), 32'd0);
        chk("r_mem_addr", mem_addr, 32'd0);
        chk("r_mem_we", 32'(mem_we), 32'd0);
        chk("r_mem_wdata", mem_wdata, 32'd0);
        chk("r_dm_rdata", dm_rdata, 32'd0);
        chk("r_if_rdata", if_rdata, 32'd0);
        rst = 0;
        mem_never = 0;
        inject_ack = 1;
        @(negedge clk);
        inject_ack = 0;
        chk("r_late_ack", 32'(mem_ack), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("r_no_dm_valid", 32'(dm_valid), 32'd0);
            chk("r_no_if_valid", 32'(if_valid), 32'd0);
            chk("r_idle", 32'(mem_req), 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
